// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the time-shared FIR MAC scheduler.
package fir_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    TAPS  = 3'd2,
    DRAIN = 3'd3,
    STORE = 3'd4
  } state_e;

  // Arithmetic shift then clamp to the signed dw-bit range.
  // Operates on wide containers so one function serves any ACCW < 128, DW <= 64.
  function automatic logic signed [63:0] sat_shift(input logic signed [127:0] acc,
                                                  input int shift, input int dw);
    logic signed [127:0] sh, hi, lo;
    sh = acc >>> shift;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (sh > hi) return hi[63:0];
    if (sh < lo) return lo[63:0];
    return sh[63:0];
  endfunction

  // Delay-line address {ch, ptr}.
  function automatic logic [31:0] pack_addr(input logic [31:0] ch, input logic [31:0] ptr,
                                            input int pw);
    return (ch << pw) | ptr;
  endfunction

endpackage

// File: rtl/fir_sched_valid_pipe.sv
// Delays the {tap-valid, first-tap} pair to line up with RAM/ROM read data.
module fir_sched_valid_pipe #(
  parameter int STAGES = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic en_o,
  output logic clr_o
);

  generate
    if (STAGES == 0) begin : g_pass
      assign en_o  = en_i;
      assign clr_o = clr_i;
    end else begin : g_pipe
      logic [STAGES:0]   vld_pipe, clr_pipe;
      logic [STAGES-1:0] vld_q, clr_q;

      assign vld_pipe = {vld_q, en_i};
      assign clr_pipe = {clr_q, clr_i};

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          vld_q <= '0;
          clr_q <= '0;
        end else begin
          vld_q <= vld_pipe[STAGES-1:0];
          clr_q <= clr_pipe[STAGES-1:0];
        end
      end

      assign en_o  = vld_pipe[STAGES];
      assign clr_o = clr_pipe[STAGES];
    end
  endgenerate

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shares one RAM-based FIR MAC engine across CHANNELS channels:
// writes every tick, convolves and emits a decimated result every DOWNSAMPLE_FACTOR-th tick.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DW                = 24,
  parameter int ACCW              = 48,
  parameter int LEN               = 254,
  parameter int PW                = 8,
  parameter int CHANNELS          = 2,
  parameter int CW                = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int DOWNSAMPLE_FACTOR = 8,
  parameter int RD_LAT            = 1,
  parameter int MAC_LAT           = 1,
  parameter int SHIFT             = 23
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   sample_tick_i,
  input  logic [CHANNELS*DW-1:0] data_i,
  output logic                   dl_wr_en_o,
  output logic [CW+PW-1:0]       dl_wr_addr_o,
  output logic [DW-1:0]          dl_wr_data_o,
  output logic [CW+PW-1:0]       dl_rd_addr_o,
  output logic [PW-1:0]          coef_rd_addr_o,
  output logic                   mac_en_o,
  output logic                   mac_clr_o,
  input  logic [ACCW-1:0]        mac_acc_i,
  output logic [DW-1:0]          data_o,
  output logic [CW-1:0]          channel_o,
  output logic                   data_valid_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int AW        = CW + PW;
  localparam int DCW       = (DOWNSAMPLE_FACTOR > 1) ? $clog2(DOWNSAMPLE_FACTOR) : 1;
  localparam int DRAIN_CYC = RD_LAT + MAC_LAT;

  state_e                 state_q, state_d;
  logic [CHANNELS*DW-1:0] samp_q, samp_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, k_q, k_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [DCW-1:0]         dec_q, dec_d;
  logic                   ovr_q, ovr_d;

  logic          last_ch, last_tap, last_drain;
  logic [PW-1:0] wr_ptr_nxt, tap_ptr;
  logic [DCW-1:0] dec_nxt;
  logic          tap_en, tap_clr;

  assign last_ch    = (32'(ch_q) == CHANNELS - 1);
  assign last_tap   = (32'(k_q) == LEN - 1);
  assign last_drain = (32'(k_q) == DRAIN_CYC - 1);
  assign wr_ptr_nxt = (32'(wr_ptr_q) == LEN - 1) ? '0 : wr_ptr_q + PW'(1);
  assign dec_nxt    = (32'(dec_q) == DOWNSAMPLE_FACTOR - 1) ? '0 : dec_q + DCW'(1);

  // Ring is LEN deep, not 2**PW, so the backwards walk must wrap at LEN-1.
  always_comb begin
    if (wr_ptr_q >= k_q) tap_ptr = wr_ptr_q - k_q;
    else                 tap_ptr = PW'(32'(wr_ptr_q) + 32'(LEN) - 32'(k_q));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      wr_ptr_q <= '0;
      k_q      <= '0;
      ch_q     <= '0;
      dec_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      wr_ptr_q <= wr_ptr_d;
      k_q      <= k_d;
      ch_q     <= ch_d;
      dec_q    <= dec_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    wr_ptr_d = wr_ptr_q;
    k_d      = k_q;
    ch_d     = ch_q;
    dec_d    = dec_q;
    ovr_d    = ovr_q | (sample_tick_i && state_q != IDLE);
    case (state_q)
      IDLE: if (sample_tick_i) begin
        samp_d  = data_i;
        ch_d    = '0;
        state_d = WRITE;
      end
      WRITE: begin
        if (!last_ch) begin
          ch_d = ch_q + CW'(1);
        end else if (dec_q == '0) begin
          ch_d    = '0;
          k_d     = '0;
          state_d = TAPS;
        end else begin
          ch_d     = '0;
          wr_ptr_d = wr_ptr_nxt;
          dec_d    = dec_nxt;
          state_d  = IDLE;
        end
      end
      TAPS: begin
        if (last_tap) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + PW'(1);
        end
      end
      DRAIN: begin
        if (last_drain) begin
          k_d     = '0;
          state_d = STORE;
        end else begin
          k_d = k_q + PW'(1);
        end
      end
      STORE: begin
        k_d = '0;
        if (last_ch) begin
          ch_d     = '0;
          wr_ptr_d = wr_ptr_nxt;
          dec_d    = dec_nxt;
          state_d  = IDLE;
        end else begin
          ch_d    = ch_q + CW'(1);
          state_d = TAPS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dl_wr_en_o     = 1'b0;
    dl_wr_addr_o   = '0;
    dl_wr_data_o   = '0;
    dl_rd_addr_o   = '0;
    coef_rd_addr_o = '0;
    tap_en         = 1'b0;
    tap_clr        = 1'b0;
    data_o         = '0;
    channel_o      = '0;
    data_valid_o   = 1'b0;
    busy_o         = (state_q != IDLE);
    case (state_q)
      WRITE: begin
        dl_wr_en_o   = 1'b1;
        dl_wr_addr_o = AW'(pack_addr(32'(ch_q), 32'(wr_ptr_q), PW));
        dl_wr_data_o = samp_q[32'(ch_q)*DW +: DW];
      end
      TAPS: begin
        dl_rd_addr_o   = AW'(pack_addr(32'(ch_q), 32'(tap_ptr), PW));
        coef_rd_addr_o = k_q;
        tap_en         = 1'b1;
        tap_clr        = (k_q == '0);
      end
      STORE: begin
        data_o       = DW'(sat_shift(128'(signed'(mac_acc_i)), SHIFT, DW));
        channel_o    = ch_q;
        data_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign overrun_o = ovr_q;

  fir_sched_valid_pipe #(.STAGES(RD_LAT)) u_vld_pipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (tap_en),
    .clr_i   (tap_clr),
    .en_o    (mac_en_o),
    .clr_o   (mac_clr_o)
  );

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: behavioural RAM/ROM/MAC, vector table plus corner-case sequences.
module tb_fir_mac_scheduler;

  localparam int DW = 24, ACCW = 48, LEN = 4, PW = 3, CH = 2, CW = 1;
  localparam int DF = 2, RD_LAT = 1, MAC_LAT = 1, SHIFT = 0;
  localparam int AW = CW + PW;
  localparam int FRAME = LEN + RD_LAT + MAC_LAT + 1;

  logic                clk_i = 1'b0, rst_n_i = 1'b0, sample_tick_i = 1'b0;
  logic [CH*DW-1:0]    data_i = '0;
  logic                dl_wr_en_o, mac_en_o, mac_clr_o, data_valid_o, busy_o, overrun_o;
  logic [AW-1:0]       dl_wr_addr_o, dl_rd_addr_o;
  logic [DW-1:0]       dl_wr_data_o, data_o;
  logic [PW-1:0]       coef_rd_addr_o;
  logic [CW-1:0]       channel_o;
  logic [ACCW-1:0]     mac_acc_i;

  fir_mac_scheduler #(
    .DW(DW), .ACCW(ACCW), .LEN(LEN), .PW(PW), .CHANNELS(CH), .CW(CW),
    .DOWNSAMPLE_FACTOR(DF), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT), .SHIFT(SHIFT)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sample_tick_i(sample_tick_i), .data_i(data_i),
    .dl_wr_en_o(dl_wr_en_o), .dl_wr_addr_o(dl_wr_addr_o), .dl_wr_data_o(dl_wr_data_o),
    .dl_rd_addr_o(dl_rd_addr_o), .coef_rd_addr_o(coef_rd_addr_o),
    .mac_en_o(mac_en_o), .mac_clr_o(mac_clr_o), .mac_acc_i(mac_acc_i),
    .data_o(data_o), .channel_o(channel_o), .data_valid_o(data_valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural delay-line RAM, coefficient ROM and MAC, one cycle each.
  logic signed [DW-1:0]   mem [0:(1<<AW)-1];
  logic signed [DW-1:0]   coefs [0:(1<<PW)-1];
  logic signed [DW-1:0]   rd_q, coef_q;
  logic signed [ACCW-1:0] acc, prod, force_val;
  logic                   mem_clr = 1'b0, force_en = 1'b0;

  assign prod      = ACCW'(rd_q) * ACCW'(coef_q);
  assign mac_acc_i = force_en ? force_val : acc;

  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
    end else if (dl_wr_en_o) begin
      mem[dl_wr_addr_o] <= dl_wr_data_o;
    end
    rd_q   <= mem[dl_rd_addr_o];
    coef_q <= coefs[coef_rd_addr_o];
    if (mac_en_o) acc <= mac_clr_o ? prod : acc + prod;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int ch; int d; int cyc; } exp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  exp_t sb[$];
  wr_t  wq[$];

  always @(negedge clk_i) begin
    if (dl_wr_en_o) wq.push_back('{dl_wr_addr_o, dl_wr_data_o});
    if (rst_n_i && data_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_channel", longint'(channel_o), e.ch);
        chk("out_data", longint'($signed(data_o)), e.d);
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic any_out();
    return dl_wr_en_o | (|dl_wr_addr_o) | (|dl_wr_data_o) | (|dl_rd_addr_o) |
           (|coef_rd_addr_o) | mac_en_o | mac_clr_o | (|data_o) | (|channel_o) |
           data_valid_o | busy_o | overrun_o;
  endfunction

  task automatic do_reset();
    rst_n_i = 1'b0; mem_clr = 1'b1; sample_tick_i = 1'b0;
    #1;
    chk("reset_outputs_zero", any_out(), 0);
    repeat (2) @(negedge clk_i);
    sb.delete();
    rst_n_i = 1'b1; mem_clr = 1'b0;
    @(negedge clk_i);
  endtask

  // One frame: drive tick, optionally inject an overrun tick at busy cycle ovr_at,
  // then check busy length, the two delay-line writes and that all outputs arrived.
  task automatic do_tick(input int s0, input int s1, input bit dec, input int e0, input int e1,
                         input int wp, input int ovr_at);
    int waited, busyc;
    waited = 0;
    while (busy_o && waited < 200) begin @(negedge clk_i); waited++; end
    chk("idle_before_tick", busy_o, 0);
    wq.delete();
    sample_tick_i = 1'b1;
    data_i = {DW'(s1), DW'(s0)};
    if (dec) begin
      sb.push_back('{0, e0, cyc + CH + 1*FRAME});
      sb.push_back('{1, e1, cyc + CH + 2*FRAME});
    end
    @(negedge clk_i);
    busyc = 0;
    while (busy_o && busyc < 100) begin
      busyc++;
      sample_tick_i = (busyc == ovr_at);
      if (busyc == ovr_at) data_i = {CH*DW{1'b1}};
      @(negedge clk_i);
    end
    sample_tick_i = 1'b0;
    chk("busy_cycles", busyc, dec ? CH + CH*FRAME : CH);
    chk("n_writes", wq.size(), CH);
    if (wq.size() >= 2) begin
      chk("wr_addr_ch0", wq[0].a, wp);
      chk("wr_data_ch0", longint'($signed(wq[0].d)), s0);
      chk("wr_addr_ch1", wq[1].a, (1 << PW) + wp);
      chk("wr_data_ch1", longint'($signed(wq[1].d)), s1);
    end
    chk("all_outputs_seen", sb.size(), 0);
  endtask

  typedef struct { bit rst; int s0; int s1; bit dec; int e0; int e1; int wp; } vec_t;
  vec_t tbl[19];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<PW); i++) coefs[i] = (i < LEN) ? DW'(i + 1) : '0;
    force_val = '0;

    // y[t] = x[t] + 2x[t-1] + 3x[t-2] + 4x[t-3], history zero after reset.
    tbl[0]  = '{1, 1, 0, 1, 1, 0, 0};
    tbl[1]  = '{0, 5, -2, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 3, 1, 13, -1, 2};
    tbl[3]  = '{0, -7, 1, 0, 0, 0, 3};
    tbl[4]  = '{0, 2, 2, 1, 8, 5, 0};
    tbl[5]  = '{0, 8388607, -8388608, 0, 0, 0, 1};
    tbl[6]  = '{0, 8388607, -8388608, 1, 8388607, -8388608, 2};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 3};
    tbl[8]  = '{0, 0, 0, 1, 8388607, -8388608, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 2};
    tbl[11] = '{1, 100, 0, 1, 100, 0, 0};
    tbl[12] = '{0, 100, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 100, 0, 1, 600, 0, 2};
    tbl[14] = '{0, 100, 0, 0, 0, 0, 3};
    tbl[15] = '{0, 100, 0, 1, 1000, 0, 0};
    tbl[16] = '{0, 100, 0, 0, 0, 0, 1};
    tbl[17] = '{0, 100, 0, 1, 1000, 0, 2};
    tbl[18] = '{0, 100, 0, 0, 0, 0, 3};

    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].rst) do_reset();
      do_tick(tbl[i].s0, tbl[i].s1, tbl[i].dec, tbl[i].e0, tbl[i].e1, tbl[i].wp, 0);
    end

    // Forced accumulator beyond the DW range must clamp.
    do_reset();
    force_en = 1'b1;
    force_val = ACCW'(64'sd1 <<< 30);
    do_tick(1, 1, 1, 8388607, 8388607, 0, 0);
    do_tick(0, 0, 0, 0, 0, 1, 0);
    force_val = -ACCW'(64'sd1 <<< 30);
    do_tick(0, 0, 1, -8388608, -8388608, 2, 0);
    force_en = 1'b0;

    // Tick during TAPS: sticky overrun, computation and counters undisturbed.
    do_reset();
    do_tick(3, 4, 1, 3, 4, 0, 5);
    chk("overrun_set", overrun_o, 1);
    do_tick(6, 7, 0, 0, 0, 1, 0);
    chk("overrun_sticky", overrun_o, 1);
    do_tick(0, 0, 1, 21, 26, 2, 0);
    chk("overrun_still_sticky", overrun_o, 1);

    // Reset landing in DRAIN abandons the frame without a partial output.
    do_reset();
    sample_tick_i = 1'b1;
    data_i = {DW'(-9), DW'(9)};
    @(negedge clk_i);
    sample_tick_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("busy_in_drain", busy_o, 1);
    rst_n_i = 1'b0; mem_clr = 1'b1;
    #1;
    chk("async_reset_outputs_zero", any_out(), 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1; mem_clr = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("no_valid_after_abort", sb.size(), 0);
    do_tick(9, -9, 1, 9, -9, 0, 0);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
